// File: rtl/puma_stream_pkg.sv
// ---------------------------------------------------------------------------
// puma_stream_pkg
//
// Purpose: shared widths, the unpacker state type and the byte lane select
//          used by the PUMA TX word-to-byte unpacker.
//
// Contents:
//   BYTE_W, WORD_W, BYTES_PER_WORD  stream geometry (8 / 32 / 4)
//   state_e                         unpacker FSM states {IDLE, EMIT}
//   byte_of(word, idx)              returns the idx-th byte to transmit
//
// Configuration macro: PUMA_UNPACK_LSB_FIRST_EN
//   undefined (default): byte 0 is word[31:24] (MSB-first)
//   defined            : byte 0 is word[7:0]   (LSB-first)
// ---------------------------------------------------------------------------
package puma_stream_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Constant lane slices avoid variable part-select index widths.
  function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] word,
                                                input logic [1:0]        idx);
    logic [BYTE_W-1:0] b;
    b = '0;
`ifdef PUMA_UNPACK_LSB_FIRST_EN
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
`else
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
`endif
    return b;
  endfunction

endpackage

// File: rtl/puma_word_unpacker.sv
// ---------------------------------------------------------------------------
// puma_word_unpacker
//
// Purpose: splits 32-bit payload words into a byte stream for the byte-wide
//          MAC/UDP TX path, reports per-frame length and oversize errors.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   s_data[31:0]         payload word (byte order chosen by byte_of)
//   s_valid / s_ready    word handshake
//   s_last               word is the final word of its frame
//   s_nbytes[1:0]        valid bytes of a last word (0 means 4)
//   m_data[7:0]          output byte
//   m_valid / m_ready    byte handshake
//   m_last               final byte of the frame
//   frame_done           one-cycle pulse after the final byte handshake
//   frame_len[LEN_W-1:0] byte count of the last completed frame (saturating)
//   err_oversize         frame exceeded MAX_FRAME_BYTES; held until the first
//                        byte of the next frame is accepted
//
// Configuration macro: PUMA_UNPACK_LSB_FIRST_EN (see puma_stream_pkg).
// ---------------------------------------------------------------------------
module puma_word_unpacker
  import puma_stream_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 1500,
  parameter int LEN_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [1:0]        s_nbytes,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic              err_oversize
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [1:0]          last_idx_q, last_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [LEN_W-1:0]    frame_len_q, frame_len_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;

  logic                at_last_idx;
  logic                byte_hs;
  logic                accept;
  logic [1:0]          new_last_idx;
  logic [LEN_W-1:0]    count_inc;
  logic                first_byte;

  // Output side: the held word is presented byte by byte while in EMIT.
  // s_ready also opens on the final byte handshake of a word so the next
  // word loads without a bubble.
  always_comb begin
    at_last_idx = (byte_idx_q == last_idx_q);
    m_valid     = (state_q == EMIT);
    m_data      = m_valid ? byte_of(word_q, byte_idx_q) : '0;
    m_last      = m_valid & last_q & at_last_idx;
    s_ready     = (state_q == IDLE) | ((state_q == EMIT) & m_ready & at_last_idx);
    byte_hs     = m_valid & m_ready;
    accept      = s_valid & s_ready;
    // A non-last word always carries four bytes; nbytes==0 also means four.
    new_last_idx = (s_last && (s_nbytes != 2'd0)) ? (s_nbytes - 2'd1) : 2'd3;
    count_inc    = (count_q == {LEN_W{1'b1}}) ? count_q : (count_q + 1'b1);
    first_byte   = (count_q == '0);
  end

  // Next-state for the word holder and byte index.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    last_idx_d = last_idx_q;
    byte_idx_d = byte_idx_q;
    if (accept) begin
      word_d     = s_data;
      last_d     = s_last;
      last_idx_d = new_last_idx;
      byte_idx_d = 2'd0;
      state_d    = EMIT;
    end else if (byte_hs && at_last_idx) begin
      state_d = IDLE;
    end else if (byte_hs) begin
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  // Frame accounting. The error flag is recomputed on every byte: the first
  // byte of a frame drops the old frame's error, later bytes keep it sticky.
  always_comb begin
    count_d      = count_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    if (byte_hs) begin
      err_d = (int'(count_inc) > MAX_FRAME_BYTES) | (err_q & ~first_byte);
      if (m_last) begin
        count_d      = '0;
        frame_len_d  = count_inc;
        frame_done_d = 1'b1;
      end else begin
        count_d = count_inc;
      end
    end
  end

  // State registers; reset discards any held word and partial count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      last_q       <= 1'b0;
      last_idx_q   <= 2'd0;
      byte_idx_q   <= 2'd0;
      count_q      <= '0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      last_q       <= last_d;
      last_idx_q   <= last_idx_d;
      byte_idx_q   <= byte_idx_d;
      count_q      <= count_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign frame_done   = frame_done_q;
  assign frame_len    = frame_len_q;
  assign err_oversize = err_q;

endmodule

// File: tb/tb_puma_word_unpacker.sv
// ---------------------------------------------------------------------------
// tb_puma_word_unpacker
//
// Bench for puma_word_unpacker. Stimulus pushes expected bytes (with frame
// position and length) into a queue; a monitor process pops and compares on
// every byte handshake and tracks frame_done / frame_len / err_oversize.
// ---------------------------------------------------------------------------
module tb_puma_word_unpacker;

  localparam int MAX_BYTES = 8;
  localparam int LEN_W     = 16;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         pos;
    int         flen;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [31:0]      s_data;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  logic [1:0]       s_nbytes;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             err_oversize;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  int   stim_pos     = 0;

  int         rdy_mode   = 0;
  logic [7:0] stall_byte = 8'h00;
  int         stall_left = 0;

  logic             exp_done = 1'b0;
  logic [LEN_W-1:0] exp_len  = '0;
  logic             exp_err  = 1'b0;

  puma_word_unpacker #(
    .MAX_FRAME_BYTES(MAX_BYTES),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_last(s_last),
    .s_nbytes(s_nbytes),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .frame_done(frame_done),
    .frame_len(frame_len),
    .err_oversize(err_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside a bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Byte k of a word in transmit order, from plain shifts.
  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
    logic [31:0] t;
`ifdef PUMA_UNPACK_LSB_FIRST_EN
    t = w >> (8 * k);
`else
    t = w >> (8 * (3 - k));
`endif
    return t[7:0];
  endfunction

  // Downstream ready: 0 = always ready, 1 = random, 3 = stall on stall_byte.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (m_valid && (m_data == stall_byte) && (stall_left > 0)) begin
            m_ready = 1'b0;
            stall_left--;
          end else begin
            m_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: compares each presented byte against the queue head and the
  // frame status outputs against the values the last handshake implies.
  initial begin
    logic next_done;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_done = 1'b0;
        exp_len  = '0;
        exp_err  = 1'b0;
      end else begin
        checkOutput("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
        checkOutput("frame_len", {16'd0, frame_len}, {16'd0, exp_len});
        checkOutput("err_oversize", {31'd0, err_oversize}, {31'd0, exp_err});
        next_done = 1'b0;
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_m_valid", {31'd0, m_valid}, 32'd0);
          end else begin
            e = exp_q[0];
            checkOutput("m_data", {24'd0, m_data}, {24'd0, e.data});
            checkOutput("m_last", {31'd0, m_last}, {31'd0, e.last});
            if (m_ready) begin
              void'(exp_q.pop_front());
              next_done = e.last;
              if (e.last) exp_len = LEN_W'((e.flen > 65535) ? 65535 : e.flen);
              exp_err = (e.pos > MAX_BYTES);
            end
          end
        end
        exp_done = next_done;
      end
    end
  end

  // Queue the expected bytes of one word, then offer it until accepted.
  task automatic applyStimulus(input logic [31:0] w, input logic last,
                               input logic [1:0] nb);
    int   n;
    exp_t e;
    bit   accepted;
    n = (last && nb != 2'd0) ? int'(nb) : 4;
    for (int k = 0; k < n; k++) begin
      stim_pos++;
      e.data = exp_byte(w, k);
      e.last = last && (k == n - 1);
      e.pos  = stim_pos;
      e.flen = stim_pos;
      exp_q.push_back(e);
    end
    if (last) stim_pos = 0;
    s_data   = w;
    s_last   = last;
    s_nbytes = nb;
    s_valid  = 1'b1;
    accepted = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        accepted = 1;
        break;
      end
    end
    if (!accepted) checkOutput("word_accept", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("drain", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int stall_seen;
    int cyc;
    int nwords;
    rst_n    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_nbytes = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", {24'd0, m_data}, 32'd0);
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single full word; first byte appears the cycle after accept.
    rdy_mode = 0;
    applyStimulus(32'hAABBCCDD, 1'b1, 2'd0);
    @(negedge clk);
    checkOutput("latency_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("latency_data", {24'd0, m_data}, {24'd0, exp_byte(32'hAABBCCDD, 0)});
    waitDrain();

    // One-byte frame.
    @(posedge clk); #1;
    applyStimulus(32'hEF0000FF, 1'b1, 2'd1);
    waitDrain();

    // Back-to-back words: seven bytes with no bubble.
    @(posedge clk); #1;
    fork
      begin
        applyStimulus(32'h01020304, 1'b0, 2'd0);
        applyStimulus(32'h05060708, 1'b1, 2'd3);
      end
      begin
        cyc = 0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (m_valid) break;
        end
        for (int c = 0; c < 50; c++) begin
          cyc++;
          if (m_valid && m_ready && m_last) break;
          @(negedge clk);
        end
        checkOutput("contig_cycles", cyc, 32'd7);
      end
    join
    waitDrain();

    // Same stream with three stall cycles on byte 03.
    @(posedge clk); #1;
    stall_byte = 8'h03;
    stall_left = 3;
    rdy_mode   = 3;
    fork
      begin
        applyStimulus(32'h01020304, 1'b0, 2'd0);
        applyStimulus(32'h05060708, 1'b1, 2'd3);
      end
      begin
        stall_seen = 0;
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (m_valid && !m_ready) begin
            stall_seen++;
            checkOutput("stall_data", {24'd0, m_data}, 32'h03);
            checkOutput("stall_s_ready", {31'd0, s_ready}, 32'd0);
          end
          if (m_valid && m_ready && m_last) break;
        end
        checkOutput("stall_cycles", stall_seen, 32'd3);
      end
    join
    waitDrain();
    rdy_mode = 0;

    // Oversize frame: twelve bytes against a limit of eight.
    @(posedge clk); #1;
    applyStimulus(32'h10111213, 1'b0, 2'd0);
    applyStimulus(32'h20212223, 1'b0, 2'd0);
    applyStimulus(32'h30313233, 1'b1, 2'd0);
    waitDrain();
    checkOutput("oversize_sticky", {31'd0, err_oversize}, 32'd1);

    // Reset while byte 1 of a word is stalled.
    @(posedge clk); #1;
    stall_byte = exp_byte(32'h11223344, 1);
    stall_left = 1000;
    rdy_mode   = 3;
    applyStimulus(32'h11223344, 1'b1, 2'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid && m_data == stall_byte) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n      = 1'b1;
    rdy_mode   = 0;
    stall_left = 0;
    stim_pos   = 0;
    @(negedge clk);
    checkOutput("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("mid_rst_m_last", {31'd0, m_last}, 32'd0);
    checkOutput("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err_oversize}, 32'd0);
    checkOutput("mid_rst_frame_len", {16'd0, frame_len}, 32'd0);
    @(posedge clk); #1;
    applyStimulus(32'h55000055, 1'b1, 2'd1);
    waitDrain();
    checkOutput("post_rst_frame_len", {16'd0, frame_len}, 32'd1);

    // Randomized frames with random backpressure and source gaps.
    @(posedge clk); #1;
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      nwords = $urandom_range(1, 4);
      for (int w = 0; w < nwords; w++) begin
        applyStimulus($urandom, (w == nwords - 1), 2'($urandom_range(0, 3)));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    waitDrain();
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
